// File: rtl/timer_pkg.sv
// Shared definitions for the timer bank: channel state encoding and mode constants.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package timer_pkg;

  // Channel FSM state encoding
  typedef logic [1:0] state_t;
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // Channel mode, sampled with start
  localparam logic ONESHOT  = 1'b0;
  localparam logic PERIODIC = 1'b1;

endpackage

// File: rtl/timer_chan.sv
// One timer channel: IDLE/RUN/DONE FSM counting up to a shadowed terminal count.
// Latency: first expire registers P edges after the start edge; outputs are registered.
// Backpressure: none; start/stop strobes are accepted every cycle (start wins over stop).
//
// Ports:
//   clk, reset_n         clock and asynchronous active-low reset
//   start, stop          (re)start and cancel strobes
//   periodic, period     mode and terminal count, captured only on start
//   running, done        channel in RUN; sticky completion level
//   expire               one-cycle pulse per terminal count
module timer_chan
  import timer_pkg::*;
#(
  parameter int CW = 32
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic          start,
  input  logic          stop,
  input  logic          periodic,
  input  logic [CW-1:0] period,
  output logic          running,
  output logic          done,
  output logic          expire
);

  state_t        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] shadow_period_q, shadow_period_d;
  logic          shadow_mode_q, shadow_mode_d;
  logic          done_q, done_d;
  logic          expire_q, expire_d;

  logic [CW-1:0] last_count;
  logic          term_hit;

  // A period of 0 behaves as 1, so the terminal value is 0 in both cases.
  // Comparing before incrementing keeps count below 2^CW-1 even for the
  // largest legal period, so it can never wrap.
  assign last_count = (shadow_period_q == '0) ? '0 : (shadow_period_q - CW'(1));
  assign term_hit   = (state_q == ST_RUN) && (count_q == last_count);

  always_comb begin
    state_d         = state_q;
    count_d         = count_q;
    shadow_period_d = shadow_period_q;
    shadow_mode_d   = shadow_mode_q;
    done_d          = done_q;
    expire_d        = 1'b0;

    if (start) begin
      // Start also covers start+stop and retrigger: the aborted interval
      // produces no expire because expire_d stays low here.
      state_d         = ST_RUN;
      count_d         = '0;
      shadow_period_d = period;
      shadow_mode_d   = periodic;
      done_d          = 1'b0;
    end else if (stop) begin
      state_d = ST_IDLE;
      count_d = '0;
      done_d  = 1'b0;
    end else if (state_q == ST_RUN) begin
      if (term_hit) begin
        expire_d = 1'b1;
        done_d   = 1'b1;
        if (shadow_mode_q == PERIODIC) begin
          count_d = '0;
        end else begin
          state_d = ST_DONE; // count stays frozen at the terminal value
        end
      end else begin
        count_d = count_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q         <= ST_IDLE;
      count_q         <= '0;
      shadow_period_q <= '0;
      shadow_mode_q   <= ONESHOT;
      done_q          <= 1'b0;
      expire_q        <= 1'b0;
    end else begin
      state_q         <= state_d;
      count_q         <= count_d;
      shadow_period_q <= shadow_period_d;
      shadow_mode_q   <= shadow_mode_d;
      done_q          <= done_d;
      expire_q        <= expire_d;
    end
  end

  assign running = (state_q == ST_RUN);
  assign done    = done_q;
  assign expire  = expire_q;

endmodule

// File: rtl/timer_bank.sv
// Bank of NCH independent timer channels with a combined completion flag.
// Latency: per channel, expire registers P edges after start; any_done follows done combinationally.
// Backpressure: none; every channel accepts strobes every cycle, no shared arbitration.
//
// Ports:
//   clk, reset_n               clock and asynchronous active-low reset
//   start, stop, periodic      per-channel strobes and mode (bit i = channel i)
//   period                     channel i terminal count at [i*CW +: CW]
//   running, done, expire      per-channel registered status
//   any_done                   OR of done
module timer_bank
  import timer_pkg::*;
#(
  parameter int NCH = 4,
  parameter int CW  = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NCH-1:0]    start,
  input  logic [NCH-1:0]    stop,
  input  logic [NCH-1:0]    periodic,
  input  logic [NCH*CW-1:0] period,
  output logic [NCH-1:0]    running,
  output logic [NCH-1:0]    done,
  output logic [NCH-1:0]    expire,
  output logic              any_done
);

  for (genvar i = 0; i < NCH; i++) begin : g_chan
    timer_chan #(
      .CW(CW)
    ) u_chan (
      .clk     (clk),
      .reset_n (reset_n),
      .start   (start[i]),
      .stop    (stop[i]),
      .periodic(periodic[i]),
      .period  (period[i*CW +: CW]),
      .running (running[i]),
      .done    (done[i]),
      .expire  (expire[i])
    );
  end

  assign any_done = |done;

endmodule

// File: tb/tb_timer_bank.sv
// Self-checking bench for timer_bank: directed scenarios plus randomized traffic
// compared each cycle against an elapsed-time reference model.
module tb_timer_bank;
  localparam int NCH = 4;
  localparam int CW  = 8;

  logic              clk = 1'b0;
  logic              reset_n;
  logic [NCH-1:0]    start, stop, periodic;
  logic [NCH*CW-1:0] period;
  logic [NCH-1:0]    running, done, expire;
  logic              any_done;

  timer_bank #(.NCH(NCH), .CW(CW)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .start   (start),
    .stop    (stop),
    .periodic(periodic),
    .period  (period),
    .running (running),
    .done    (done),
    .expire  (expire),
    .any_done(any_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Reference model: a channel is "armed" from its start edge; it expires on
  // every edge whose distance from the start edge is a multiple of P.
  bit m_arm [NCH];
  bit m_per [NCH];
  bit m_done[NCH];
  bit m_exp [NCH];
  int m_t0  [NCH];
  int m_p   [NCH];
  int edge_n = 0;

  function automatic void model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_arm[i] = 0; m_per[i] = 0; m_done[i] = 0; m_exp[i] = 0;
      m_t0[i] = 0; m_p[i] = 1;
    end
  endfunction

  function automatic void model_edge();
    int el;
    logic [CW-1:0] p;
    for (int i = 0; i < NCH; i++) begin
      if (start[i]) begin
        p = period[i*CW +: CW];
        m_arm[i] = 1; m_t0[i] = edge_n; m_p[i] = (p == 0) ? 1 : int'(p);
        m_per[i] = periodic[i]; m_done[i] = 0; m_exp[i] = 0;
      end else if (stop[i]) begin
        m_arm[i] = 0; m_done[i] = 0; m_exp[i] = 0;
      end else if (m_arm[i]) begin
        el = edge_n - m_t0[i];
        if (el % m_p[i] == 0) begin
          m_exp[i] = 1; m_done[i] = 1;
          if (!m_per[i]) m_arm[i] = 0;
        end else begin
          m_exp[i] = 0;
        end
      end else begin
        m_exp[i] = 0;
      end
    end
  endfunction

  task automatic compare_all(input string tag);
    logic [NCH-1:0] er, ed, ee;
    for (int i = 0; i < NCH; i++) begin
      er[i] = m_arm[i]; ed[i] = m_done[i]; ee[i] = m_exp[i];
    end
    check({tag, ".running"}, 32'(running), 32'(er));
    check({tag, ".done"},    32'(done),    32'(ed));
    check({tag, ".expire"},  32'(expire),  32'(ee));
    check({tag, ".any_done"}, 32'(any_done), 32'(|ed));
  endtask

  // One clock: DUT and model see the same inputs at the edge, outputs are
  // compared on the falling edge, then strobes are dropped.
  task automatic step(input string tag);
    @(posedge clk);
    edge_n++;
    model_edge();
    @(negedge clk);
    compare_all(tag);
    start = '0;
    stop  = '0;
  endtask

  task automatic arm(input int ch, input int p, input bit per);
    start[ch] = 1'b1;
    periodic[ch] = per;
    period[ch*CW +: CW] = CW'(p);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic pulse_reset(input string tag);
    #2;
    reset_n = 1'b0;
    #1;
    model_reset();
    compare_all({tag, ".imm"});
    @(posedge clk);
    @(negedge clk);
    compare_all({tag, ".held"});
    start = '0; stop = '0;
    reset_n = 1'b1;
  endtask

  // Start channel ch and count edges until its first expire.
  task automatic measure(input string tag, input int ch, input int p, input int want);
    int n;
    arm(ch, p, 1'b0);
    step(tag);
    n = 0;
    for (int j = 1; j <= 300; j++) begin
      step(tag);
      if (expire[ch] === 1'b1) begin n = j; break; end
    end
    if (n == 0) n = 301;
    check({tag, ".latency"}, 32'(n), 32'(want));
  endtask

  int cnt;

  initial begin
    reset_n = 1'b0; start = '0; stop = '0; periodic = '0; period = '0;
    model_reset();
    #1;
    compare_all("reset");
    repeat (2) @(negedge clk);
    compare_all("reset_hold");
    reset_n = 1'b1;
    for (int j = 0; j < 3; j++) step("idle_after_reset");

    // One-shot, period 8, then remains DONE
    measure("oneshot8", 0, 8, 8);
    for (int j = 0; j < 5; j++) step("oneshot8_tail");
    check("oneshot8.done_sticky", 32'(done[0]), 32'd1);

    // Periodic 5 on channel 1, stopped at k+12
    cnt = 0;
    arm(1, 5, 1'b1);
    step("periodic5");
    for (int j = 1; j <= 16; j++) begin
      if (j == 12) stop[1] = 1'b1;
      step("periodic5");
      if (expire[1] === 1'b1) cnt++;
    end
    check("periodic5.pulses", 32'(cnt), 32'd2);
    check("periodic5.done_after_stop", 32'(done[1]), 32'd0);

    // Retrigger at k+6 of a period-10 run
    cnt = 0;
    arm(2, 10, 1'b0);
    step("retrig");
    for (int j = 1; j <= 20; j++) begin
      if (j == 6) arm(2, 10, 1'b0);
      step("retrig");
      if (expire[2] === 1'b1) begin
        cnt++;
        check("retrig.edge", 32'(j), 32'd16);
      end
    end
    check("retrig.pulses", 32'(cnt), 32'd1);

    // Boundary periods
    measure("period0", 3, 0, 1);
    measure("period255", 3, 255, 255);

    // Reset mid-run, no expire afterwards
    cnt = 0;
    arm(0, 8, 1'b0);
    step("rst_mid");
    for (int j = 1; j <= 3; j++) step("rst_mid");
    pulse_reset("rst_mid");
    for (int j = 0; j < 17; j++) begin
      step("rst_after");
      if (expire !== '0 || running !== '0 || done !== '0) cnt++;
    end
    check("rst_after.activity", 32'(cnt), 32'd0);

    // Start+stop on ch2 while ch3 runs periodically
    arm(3, 3, 1'b1);
    step("indep");
    step("indep");
    arm(2, 4, 1'b0);
    stop[2] = 1'b1;
    step("indep");
    for (int j = 0; j < 8; j++) step("indep");
    stop[3] = 1'b1;
    step("indep");

    // Randomized traffic, including mode/period changes mid-run
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < NCH; i++) begin
        periodic[i] = 1'($urandom_range(0, 1));
        period[i*CW +: CW] = ($urandom_range(0, 7) == 0) ? CW'($urandom_range(0, 255))
                                                          : CW'($urandom_range(0, 12));
        start[i] = ($urandom_range(0, 11) == 0);
        stop[i]  = ($urandom_range(0, 15) == 0);
      end
      if ($urandom_range(0, 499) == 0) begin
        pulse_reset("rand_rst");
      end else begin
        step("rand");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/timer_bank.md
TIMER_BANK -- requirements
Module: timer_bank

Interface
- REQ-001: Parameter NCH, default 4, number of independent timer channels (1..16).
- REQ-002: Parameter CW, default 32, counter and period width in bits (4..32).
- REQ-003: clk  input  1  single clock; all state updates on its rising edge.
- REQ-004: reset_n  input  1  asynchronous, active-low reset.
- REQ-005: start  input  NCH  per-channel (re)start strobe, sampled each edge.
- REQ-006: stop  input  NCH  per-channel cancel strobe.
- REQ-007: periodic  input  NCH  per-channel mode, sampled with start (0 = one-shot, 1 = periodic).
- REQ-008: period  input  NCH*CW  flattened per-channel terminal counts, channel i at bits [i*CW +: CW], sampled with start.
- REQ-009: running  output  NCH  channel in RUN state.
- REQ-010: done  output  NCH  sticky completion level.
- REQ-011: expire  output  NCH  one-cycle pulse on each terminal count.
- REQ-012: any_done  output  1  OR of done.

Function
- REQ-013: Each channel SHALL be an FSM with states IDLE, RUN and DONE.
- REQ-014: start[i] high at edge k SHALL load count=0, capture period and periodic into shadow registers, clear done[i], and enter RUN from any state.
- REQ-015: In RUN, count SHALL increment by 1 per edge; at the edge where count == shadow_period-1, expire[i] SHALL be high for exactly the following cycle, i.e. first expire registers at edge k+P.
- REQ-016: A shadow period of 0 SHALL be treated as 1.
- REQ-017: On terminal count in one-shot mode, the channel SHALL enter DONE with done[i]=1 and the count frozen.
- REQ-018: On terminal count in periodic mode, the channel SHALL set done[i]=1, reload count=0 and stay in RUN, giving an expire pulse every P cycles.
- REQ-019: stop[i] SHALL return the channel to IDLE, clear done[i] and suppress expire[i] on that edge.
- REQ-020: start[i] and stop[i] high together SHALL act as start.
- REQ-021: A start during RUN SHALL retrigger with no expire for the aborted interval.
- REQ-022: Changes to period or periodic while in RUN SHALL take effect only at the next start.
- REQ-023: The count SHALL never wrap, because the terminal compare precedes increment; P = 2^CW-1 SHALL be legal.
- REQ-024: Channels SHALL be fully independent, with no shared arbitration.
- REQ-025: running, done and expire SHALL be registered outputs; any_done is combinational from registered done.

Reset
- REQ-026: reset_n low SHALL immediately force every channel to IDLE with count=0, shadow registers 0, and running=done=expire=0, any_done=0.
- REQ-027: Reset asserted mid-RUN SHALL discard the interval; no expire SHALL follow reset release.
- REQ-028: After reset_n rises, channels SHALL remain IDLE until a start.

Structure
- REQ-029: A shared package timer_pkg SHALL hold the state encoding (IDLE/RUN/DONE) and the mode constants ONESHOT=0 and PERIODIC=1.
- REQ-030: One sub-module timer_chan (one channel, parameter CW) SHALL be instantiated NCH times by a generate loop in timer_bank.

Verification
- REQ-031: NCH=4, CW=8; start[0] at edge 10, period=8, one-shot -> expire[0] single pulse after edge 18, done[0] high from edge 18 onward, running[0] low from edge 18.
- REQ-032: Periodic, period=5 on channel 1 -> expire[1] after edges k+5, k+10, k+15; stop at k+12 -> no pulse at k+15, done[1]=0.
- REQ-033: Retrigger: period=10, second start at k+6 -> single expire at k+16, none at k+10.
- REQ-034: period=0 and period=255 one-shot -> expire at k+1 and k+255 respectively, with no wrap.
- REQ-035: reset_n pulsed low at k+3 of a period=8 run -> all outputs 0 immediately and stay 0 through k+20.
- REQ-036: Simultaneous start and stop on channel 2 with period=4 while channel 3 is running -> channel 2 restarts and expires at k+4; channel 3 timing is unaffected.
